// File: rtl/instruction_queue_if.sv
// Host byte bus and consumer port of the instruction queue.
// Optional o_timeout exists only when INSTR_QUEUE_TIMEOUT_EN is defined.
interface instruction_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          i_en;
    logic          i_we;
    logic [7:0]    i_data;
    logic          o_ack;
    logic          i_flush;
    logic [31:0]   o_instruction;
    logic          o_ready;
    logic          i_pop;
    logic          o_full;
    logic [CW-1:0] o_count;
`ifdef INSTR_QUEUE_TIMEOUT_EN
    logic          o_timeout;
`endif

    // Host plus consumer side.
    modport master (
        output i_en, i_we, i_data, i_flush, i_pop,
`ifdef INSTR_QUEUE_TIMEOUT_EN
        input  o_timeout,
`endif
        input  o_ack, o_instruction, o_ready, o_full, o_count
    );

    // Queue side.
    modport slave (
        input  i_en, i_we, i_data, i_flush, i_pop,
`ifdef INSTR_QUEUE_TIMEOUT_EN
        output o_timeout,
`endif
        output o_ack, o_instruction, o_ready, o_full, o_count
    );
endinterface

// File: rtl/instruction_queue.sv
// Byte-to-word assembler feeding a first-word-fall-through instruction FIFO.
// Define INSTR_QUEUE_TIMEOUT_EN to discard stale partial words after TIMEOUT_CYCLES.
module instruction_queue #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    instruction_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("instruction_queue: DEPTH must be a power of two in 2..16");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("instruction_queue: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        B0,
        B1,
        B2,
        B3
    } asm_state_e;

    asm_state_e    state_q;
    logic [23:0]   asm_q;
    logic          ack_q;
    logic          run_meta_q;
    logic          run_q;
    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    logic          full;
    logic          ready;
    logic          stall;
    logic          accept;
    logic          push;
    logic          pop;
    logic [31:0]   push_word;

    assign full      = (count_q == CW'(DEPTH));
    assign ready     = (count_q != '0);
    // Only the word-completing byte can be blocked, and a pop frees its slot.
    assign stall     = (state_q == B3) && full && !bus.i_pop;
    assign accept    = run_q && !bus.i_flush && bus.i_en && bus.i_we && !stall;
    assign push      = accept && (state_q == B3);
    assign pop       = !bus.i_flush && bus.i_pop && ready;
    assign push_word = {bus.i_data, asm_q};

    // Release of reset is seen by the core two edges later, so the first edge accepts nothing.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            run_meta_q <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            run_meta_q <= 1'b1;
            run_q      <= run_meta_q;
        end
    end

`ifdef INSTR_QUEUE_TIMEOUT_EN
    localparam int IW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    logic [IW-1:0] idle_q;
    logic          timeout_q;

    // Assembler FSM with idle watchdog on partial words.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= B0;
            asm_q     <= '0;
            ack_q     <= 1'b0;
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            ack_q     <= accept;
            timeout_q <= 1'b0;
            if (bus.i_flush) begin
                state_q <= B0;
                idle_q  <= '0;
            end else if (accept) begin
                idle_q <= '0;
                case (state_q)
                    B0: begin
                        asm_q[7:0] <= bus.i_data;
                        state_q    <= B1;
                    end
                    B1: begin
                        asm_q[15:8] <= bus.i_data;
                        state_q     <= B2;
                    end
                    B2: begin
                        asm_q[23:16] <= bus.i_data;
                        state_q      <= B3;
                    end
                    B3: begin
                        state_q <= B0;
                    end
                endcase
            end else if (state_q == B0) begin
                idle_q <= '0;
            end else if (idle_q == IW'(TIMEOUT_CYCLES - 1)) begin
                state_q   <= B0;
                idle_q    <= '0;
                timeout_q <= 1'b1;
            end else begin
                idle_q <= idle_q + 1'b1;
            end
        end
    end

    assign bus.o_timeout = timeout_q;
`else
    // Assembler FSM; a partial word waits for its remaining bytes indefinitely.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= B0;
            asm_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= accept;
            if (bus.i_flush) begin
                state_q <= B0;
            end else if (accept) begin
                case (state_q)
                    B0: begin
                        asm_q[7:0] <= bus.i_data;
                        state_q    <= B1;
                    end
                    B1: begin
                        asm_q[15:8] <= bus.i_data;
                        state_q     <= B2;
                    end
                    B2: begin
                        asm_q[23:16] <= bus.i_data;
                        state_q      <= B3;
                    end
                    B3: begin
                        state_q <= B0;
                    end
                endcase
            end
        end
    end
`endif

    // Entry count follows push and pop together; flush empties the queue.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Queue pointers and count; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (bus.i_flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Storage array, left unreset.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wptr_q] <= push_word;
        end
    end

    assign bus.o_ack         = ack_q;
    assign bus.o_instruction = mem_q[rptr_q];
    assign bus.o_ready       = ready;
    assign bus.o_full        = full;
    assign bus.o_count       = count_q;
endmodule

// File: tb/tb_instruction_queue.sv
// Scoreboard bench for instruction_queue.
// Expected words are queued when their last byte is acked and compared on pop.
module tb_instruction_queue;
    localparam int DEPTH = 4;
`ifdef INSTR_QUEUE_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] sb[$];
    logic [31:0] wds[5];
    int          wt;

    instruction_queue_if #(.DEPTH(DEPTH)) bus();

    instruction_queue #(
        .DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk(clk),
        .i_reset_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, output int waited);
        bus.i_en   = 1'b1;
        bus.i_we   = 1'b1;
        bus.i_data = b;
        waited     = 0;
        do begin
            tick();
            waited++;
        end while (!bus.o_ack && waited < 16);
        if (!bus.o_ack) check("ack_wait_expired", {31'b0, bus.o_ack}, 32'd1);
    endtask

    task automatic bus_idle();
        bus.i_en = 1'b0;
        bus.i_we = 1'b0;
    endtask

    task automatic write_word(input logic [31:0] w);
        int wt2;
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], wt2);
        bus_idle();
        sb.push_back(w);
    endtask

    task automatic pop_check(input string tag);
        check({tag, "_ready"}, {31'b0, bus.o_ready}, 32'd1);
        if (sb.size() == 0) check("sb_empty", sb.size(), 32'd1);
        else check(tag, bus.o_instruction, sb.pop_front());
        bus.i_pop = 1'b1;
        tick();
        bus.i_pop = 1'b0;
    endtask

    initial begin
        bus.i_en    = 1'b0;
        bus.i_we    = 1'b0;
        bus.i_data  = 8'h00;
        bus.i_flush = 1'b0;
        bus.i_pop   = 1'b0;
        #2;
        check("rst_ready", {31'b0, bus.o_ready}, 32'd0);
        check("rst_full",  {31'b0, bus.o_full},  32'd0);
        check("rst_ack",   {31'b0, bus.o_ack},   32'd0);
        check("rst_count", 32'(bus.o_count),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();

        // Basic word, back-to-back bytes.
        send_byte(8'h01, wt); check("b2b_0", wt, 32'd1);
        send_byte(8'h2A, wt); check("b2b_1", wt, 32'd1);
        send_byte(8'h00, wt); check("b2b_2", wt, 32'd1);
        send_byte(8'h00, wt); check("b2b_3", wt, 32'd1);
        bus_idle();
        sb.push_back(32'h00002A01);
        check("basic_count", 32'(bus.o_count), 32'd1);
        pop_check("basic_word");
        check("basic_empty", {31'b0, bus.o_ready}, 32'd0);

        // Disabled or non-write bytes are ignored.
        bus.i_en = 1'b1; bus.i_we = 1'b0; bus.i_data = 8'hEE;
        repeat (2) begin tick(); check("we_low_ack", {31'b0, bus.o_ack}, 32'd0); end
        bus.i_en = 1'b0; bus.i_we = 1'b1;
        repeat (2) begin tick(); check("en_low_ack", {31'b0, bus.o_ack}, 32'd0); end
        bus_idle();
        write_word(32'h44332211);
        pop_check("after_ignored");

        // Fill to DEPTH, stall the fifth word's last byte.
        for (int k = 0; k < 5; k++) wds[k] = 32'hA0B0C000 | k | (k << 12);
        for (int k = 0; k < 4; k++) write_word(wds[k]);
        check("full_flag",  {31'b0, bus.o_full}, 32'd1);
        check("full_count", 32'(bus.o_count),    32'd4);
        send_byte(wds[4][7:0],   wt); check("full_b0", wt, 32'd1);
        send_byte(wds[4][15:8],  wt); check("full_b1", wt, 32'd1);
        send_byte(wds[4][23:16], wt); check("full_b2", wt, 32'd1);
        bus.i_data = wds[4][31:24];
        repeat (3) begin
            tick();
            check("stall_ack",   {31'b0, bus.o_ack}, 32'd0);
            check("stall_count", 32'(bus.o_count),   32'd4);
        end
        check("stall_head", bus.o_instruction, sb[0]);
        bus.i_pop = 1'b1;
        tick();
        bus.i_pop = 1'b0;
        check("unstall_ack",   {31'b0, bus.o_ack}, 32'd1);
        check("unstall_count", 32'(bus.o_count),   32'd4);
        bus_idle();
        void'(sb.pop_front());
        sb.push_back(wds[4]);
        for (int k = 0; k < 4; k++) pop_check("drain_full");
        check("drained", 32'(bus.o_count), 32'd0);

        // Push and pop together at count 1: new word becomes head.
        write_word(32'h11111111);
        send_byte(8'h04, wt); send_byte(8'h03, wt); send_byte(8'h02, wt);
        bus.i_data = 8'h01;
        bus.i_pop  = 1'b1;
        tick();
        bus.i_pop = 1'b0;
        bus_idle();
        check("pp1_ack",   {31'b0, bus.o_ack}, 32'd1);
        check("pp1_count", 32'(bus.o_count),   32'd1);
        void'(sb.pop_front());
        sb.push_back(32'h01020304);
        pop_check("pp1_head");

        // Flush drops a partial word and the byte presented with it.
        send_byte(8'h55, wt); send_byte(8'h66, wt);
        bus.i_data  = 8'h77;
        bus.i_flush = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        bus_idle();
        check("flush_ack", {31'b0, bus.o_ack}, 32'd0);
        write_word(32'h000FFF02);
        check("flush_count", 32'(bus.o_count), 32'd1);
        pop_check("flush_word");

        // Pop on empty.
        bus.i_pop = 1'b1;
        repeat (3) begin
            tick();
            check("empty_pop_count", 32'(bus.o_count),   32'd0);
            check("empty_pop_ready", {31'b0, bus.o_ready}, 32'd0);
        end
        bus.i_pop = 1'b0;

        // Pointer wrap, one word at a time.
        for (int k = 0; k < 9; k++) begin
            write_word($urandom());
            pop_check("wrap_word");
        end

`ifdef INSTR_QUEUE_TIMEOUT_EN
        // Stale partial word is dropped; queued entry stays.
        write_word(32'hCAFE0001);
        send_byte(8'h99, wt);
        bus_idle();
        wt = 0;
        for (int c = 1; c <= TMO; c++) begin
            tick();
            if (bus.o_timeout) begin
                check("timeout_cycle", c, TMO);
                wt++;
            end
        end
        check("timeout_pulses", wt, 32'd1);
        tick();
        check("timeout_one_cycle", {31'b0, bus.o_timeout}, 32'd0);
        check("timeout_count", 32'(bus.o_count), 32'd1);
        write_word(32'hBEEF0102);
        pop_check("timeout_kept");
        pop_check("timeout_next");
`else
        // Partial word waits indefinitely.
        send_byte(8'h99, wt);
        bus_idle();
        repeat (20) tick();
        send_byte(8'h88, wt); send_byte(8'h77, wt); send_byte(8'h66, wt);
        bus_idle();
        sb.push_back(32'h66778899);
        pop_check("slow_word");
`endif

        // Reset mid-word with two entries queued.
        write_word(32'h12345678);
        write_word(32'h9ABCDEF0);
        send_byte(8'h01, wt); send_byte(8'h02, wt);
        #1;
        rst_n = 1'b0;
        #1;
        check("amid_rst_ready", {31'b0, bus.o_ready}, 32'd0);
        check("amid_rst_full",  {31'b0, bus.o_full},  32'd0);
        check("amid_rst_ack",   {31'b0, bus.o_ack},   32'd0);
        check("amid_rst_count", 32'(bus.o_count),     32'd0);
        sb.delete();
        bus.i_data = 8'h3C;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_no_accept", {31'b0, bus.o_ack}, 32'd0);
        bus_idle();
        tick();
        write_word(32'h5A5A003C);
        check("post_rst_count", 32'(bus.o_count), 32'd1);
        pop_check("post_rst_head");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/instruction_queue.md
INSTRUCTION_QUEUE -- requirements
Module: instruction_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of 32-bit instruction entries held; power of two, 2..16.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, idle cycles before a partial instruction is discarded; used only under REQ-026.
REQ-003 i_clk  input  1  single clock; all logic on posedge.
REQ-004 i_reset_n  input  1  reset, asynchronous, active-low.
REQ-005 i_en  input  1  host bus enable.
REQ-006 i_we  input  1  host write strobe, qualified by i_en.
REQ-007 i_data  input  8  host instruction byte.
REQ-008 o_ack  output  1  one-cycle pulse per accepted byte.
REQ-009 i_flush  input  1  synchronous discard of all queued and partial data.
REQ-010 o_instruction  output  32  head entry; [7:0] opcode, [31:8] arguments.
REQ-011 o_ready  output  1  queue non-empty; o_instruction valid.
REQ-012 i_pop  input  1  consumer removes head entry.
REQ-013 o_full  output  1  DEPTH entries stored.
REQ-014 o_count  output  $clog2(DEPTH)+1  stored entry count.

Function
REQ-015 Byte accept: a byte is accepted on a posedge with i_en && i_we && !stall; o_ack SHALL be high on the following cycle only; back-to-back bytes on consecutive cycles SHALL be accepted.
REQ-016 Assembler FSM SHALL have states B0, B1, B2, B3; each accepted byte advances B0->B1->B2->B3->B0; the byte accepted in state Bn lands in bits [8n+7:8n] (first byte = opcode).
REQ-017 The byte accepted in B3 SHALL push the assembled word into the queue in the same edge; the word is visible at o_instruction no later than 1 cycle after its B3 o_ack, if the queue was empty.
REQ-018 stall SHALL be asserted only when the FSM is in B3 and o_full && !i_pop; bytes in B0..B2 are always accepted, even when full.
REQ-019 A stalled byte SHALL NOT be acked or latched; the host holds i_data/i_we until o_ack.
REQ-020 Queue SHALL be first-word-fall-through: o_instruction = oldest entry whenever o_ready; value undefined-but-stable when empty.
REQ-021 i_pop with o_ready SHALL remove the head on that edge; i_pop with !o_ready SHALL be ignored with no count underflow.
REQ-022 Simultaneous push and pop SHALL leave o_count unchanged, including at full (the B3 byte is accepted) and at count 1 (new word becomes head).
REQ-023 Read/write pointers SHALL wrap modulo DEPTH; o_count = 0..DEPTH, o_full = (o_count == DEPTH), o_ready = (o_count != 0).
REQ-024 i_flush SHALL take priority over push, pop and byte accept: on that edge the FSM returns to B0, o_count becomes 0, no o_ack is generated for a byte presented that cycle.
REQ-025 Bytes with i_we low or i_en low SHALL have no effect.

Configuration
REQ-026 With INSTR_QUEUE_TIMEOUT_EN defined: an idle counter clears on every accepted byte and on B0; when the FSM sits in B1..B3 for TIMEOUT_CYCLES consecutive cycles without an accepted byte, the FSM SHALL return to B0, discarding partial bytes, and output o_timeout (1 bit) SHALL pulse for one cycle; queued entries are untouched.
REQ-027 Without INSTR_QUEUE_TIMEOUT_EN: no counter and no o_timeout port; a partial instruction waits indefinitely.

Reset
REQ-028 While i_reset_n is low, asynchronously: FSM = B0, o_count = 0, pointers = 0, o_ack = 0, o_ready = 0, o_full = 0, o_timeout = 0 (if present); storage contents need not be reset.
REQ-029 Reset asserted mid-instruction or with entries queued SHALL discard everything; deassertion is synchronised internally so the first edge after release accepts no byte.

Verification
REQ-030 Write 01 2A 00 00 on 4 consecutive cycles -> 4 o_ack pulses; o_ready rises; o_instruction = 32'h00002A01; i_pop -> o_ready = 0.
REQ-031 DEPTH=4: write 5 instructions, no pop -> o_full after 4th; 5th word's bytes 0..2 acked, byte 3 held without o_ack; assert i_pop -> byte 3 acked same cycle, o_count stays 4, head = 2nd word.
REQ-032 Write 2 bytes, i_flush for 1 cycle, then write 02 FF 0F 00 -> exactly one entry, o_instruction = 32'h000FFF02.
REQ-033 Pop on empty queue for 3 cycles -> o_count stays 0, no state change; then pointer wrap: push/pop 9 words one at a time -> each emerges in order.
REQ-034 With INSTR_QUEUE_TIMEOUT_EN, TIMEOUT_CYCLES=8: write 1 byte, idle 8 cycles -> o_timeout pulse, FSM B0; next 4 bytes form a complete instruction.
REQ-035 Assert i_reset_n low mid-word with 2 entries queued -> o_ready, o_full, o_ack drop immediately; after release first full instruction written is head.
